// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 codes
// and the legality/alignment rules applied when an access is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic access_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Size lives in f3[1:0] for every legal code, so alignment only looks there.
  function automatic logic access_aligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b01:   return !lane[0];
      2'b10:   return lane == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/response bus between the load/store unit (master)
// and data memory (slave).
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Picks the addressed byte/halfword out of a memory word and sign- or
// zero-extends it according to funct3. Purely combinational.
module load_extend
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            lane,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data
);
  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign byte_lane[gi] = rdata[gi*8 +: 8];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_half
    assign half_lane[gi] = rdata[gi*16 +: 16];
  end

  assign byte_sel = byte_lane[lane];
  assign half_sel = half_lane[lane[1]];

  always_comb begin
    case (funct3)
      F3_B:    data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      F3_H:    data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      F3_BU:   data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_HU:   data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs one load/store per instruction over the mem bus,
// stalls the core while outstanding and flags illegal/misaligned/timed-out accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_valid,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  done,
  output logic                  err,
  load_store_unit_if.master     bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t            state_reg, state_next;
  logic                  we_reg;
  logic [2:0]            f3_reg;
  logic [1:0]            lane_reg;
  logic                  err_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [3:0]            wstrb_reg;
  logic [DATA_WIDTH-1:0] read_data_reg;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] store_data;
  logic [3:0]            store_strb;
  logic                  access_ok;
  logic                  timeout_hit;

  assign access_ok   = access_legal(MemWrite, funct3) && access_aligned(funct3, ALUResult[1:0]);
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

  // Store lanes: data replicated across the word, strobes pick the live bytes.
  always_comb begin
    store_strb = 4'b0000;
    store_data = '0;
    if (MemWrite) begin
      case (funct3)
        F3_B: begin
          store_strb = 4'b0001 << ALUResult[1:0];
          store_data = {(DATA_WIDTH/8){WriteData[7:0]}};
        end
        F3_H: begin
          store_strb = 4'b0011 << ALUResult[1:0];
          store_data = {(DATA_WIDTH/16){WriteData[15:0]}};
        end
        default: begin
          store_strb = 4'b1111;
          store_data = WriteData;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    case (state_reg)
      IDLE: begin
        stall = lsu_valid;
        if (lsu_valid) state_next = access_ok ? REQ : DONE;
      end
      REQ: begin
        stall = 1'b1;
        if (bus.mem_ready || timeout_hit) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg        <= 1'b0;
      f3_reg        <= 3'b000;
      lane_reg      <= 2'b00;
      err_reg       <= 1'b0;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= 4'b0000;
      read_data_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (lsu_valid) begin
            we_reg   <= MemWrite;
            f3_reg   <= funct3;
            lane_reg <= ALUResult[1:0];
            err_reg  <= !access_ok;
            cnt_reg  <= '0;
            // Bus registers only move for accesses that will actually be issued.
            if (access_ok) begin
              addr_reg  <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
              wdata_reg <= store_data;
              wstrb_reg <= store_strb;
            end
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            if (!we_reg) read_data_reg <= load_data;
          end else if (timeout_hit) begin
            err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
    .rdata  (bus.mem_rdata),
    .lane   (lane_reg),
    .funct3 (f3_reg),
    .data   (load_data)
  );

  assign bus.mem_req   = (state_reg == REQ);
  assign bus.mem_we    = we_reg && (state_reg == REQ);
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_wdata = wdata_reg;
  assign bus.mem_wstrb = wstrb_reg;
  assign done          = (state_reg == DONE);
  assign err           = (state_reg == DONE) && err_reg;
  assign ReadData      = read_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset
// corner sequences and randomized accesses against a behavioural model.
module tb_load_store_unit;
  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        lsu_valid;
  logic        MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        stall;
  logic [31:0] ReadData;
  logic        done;
  logic        err;

  load_store_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) mem_bus ();

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lsu_valid (lsu_valid),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .stall     (stall),
    .ReadData  (ReadData),
    .done      (done),
    .err       (err),
    .bus       (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int txn_no = 0;
  logic [31:0] cur_read = 32'h0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          waits;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_read;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // Reference model: derived from the access rules with plain arithmetic.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input int waits,
                       input logic [31:0] cur,
                       output logic e, output int lat, output logic [31:0] ea,
                       output logic [3:0] es, output logic [31:0] ew, output logic [31:0] er);
    int size;
    int off;
    logic legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off   = int'(addr % 32'd4);
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    ea    = addr & 32'hFFFF_FFFC;
    es    = 4'((((1 << size) - 1) << off) & 15);
    if (size == 1)      ew = {24'h0, wd[7:0]} * 32'h0101_0101;
    else if (size == 2) ew = {16'h0, wd[15:0]} * 32'h0001_0001;
    else                ew = wd;
    er = cur;
    if (!legal || (off % size) != 0) begin
      e = 1'b1; lat = 2;
    end else if (waits >= TO) begin
      e = 1'b1; lat = TO + 2;
    end else begin
      e = 1'b0; lat = 3 + waits;
      if (!we) begin
        v = rd >> (8 * off);
        if (size == 1) begin
          v = v & 32'hFF;
          if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2) begin
          v = v & 32'hFFFF;
          if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
        end
        er = v;
      end
    end
  endtask

  // Presents one access starting just after a rising edge; plays memory with
  // `waits` not-ready REQ cycles, then checks the retirement.
  task automatic run_txn(input string nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                         input int waits, input logic exp_err, input int exp_lat,
                         input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_read);
    int cyc;
    int reqs;
    int bad_stall;
    int bad_bus;
    logic got_done;
    logic got_err;
    cyc = 0; reqs = 0; bad_stall = 0; bad_bus = 0; got_done = 1'b0; got_err = 1'b0;
    lsu_valid = 1'b1; MemWrite = we; funct3 = f3; ALUResult = addr; WriteData = wd;
    while (!got_done && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        got_done = 1'b1;
        got_err  = err;
        if (stall) bad_stall++;
        if (mem_bus.mem_req) bad_bus++;
      end else begin
        if (!stall) bad_stall++;
        if (mem_bus.mem_req) begin
          if (mem_bus.mem_addr !== exp_addr || mem_bus.mem_we !== we) bad_bus++;
          if (we && (mem_bus.mem_wstrb !== exp_strb || mem_bus.mem_wdata !== exp_wdata)) bad_bus++;
          mem_bus.mem_ready = (reqs == waits);
          mem_bus.mem_rdata = (reqs == waits) ? rd : $urandom;
          reqs++;
        end else begin
          mem_bus.mem_ready = 1'($urandom_range(0, 1));
          mem_bus.mem_rdata = $urandom;
        end
      end
      @(posedge clk);
      #1;
    end
    lsu_valid = 1'b0;
    txn_no++;
    $display("txn %0d %s we=%0b f3=%0d addr=%h cycles=%0d reqs=%0d err=%0b ReadData=%h",
             txn_no, nm, we, f3, addr, cyc, reqs, got_err, ReadData);
    check({nm, ".done"},  32'(got_done), 32'd1);
    check({nm, ".err"},   32'(got_err), 32'(exp_err));
    check({nm, ".lat"},   32'(cyc), 32'(exp_lat));
    check({nm, ".reqs"},  32'(reqs), 32'(exp_lat - 2));
    check({nm, ".stall"}, 32'(bad_stall), 32'd0);
    check({nm, ".bus"},   32'(bad_bus), 32'd0);
    check({nm, ".rdata"}, ReadData, exp_read);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        e;
    int          lat;
    logic [31:0] ea;
    logic [3:0]  es;
    logic [31:0] ew;
    logic [31:0] er;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wd;
    logic [31:0] r_rd;
    int          r_waits;
    int          r_sel;

    vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,         32'hDEADBEEF, 0,   1'b0, 3,  32'h10, 4'h0, 32'h0,         32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'h13, 32'h0,         32'h80FF1234, 0,   1'b0, 3,  32'h10, 4'h0, 32'h0,         32'hFFFFFF80};
    vecs[2]  = '{1'b0, 3'b100, 32'h13, 32'h0,         32'h80FF1234, 0,   1'b0, 3,  32'h10, 4'h0, 32'h0,         32'h00000080};
    vecs[3]  = '{1'b0, 3'b001, 32'h12, 32'h0,         32'h80FF1234, 0,   1'b0, 3,  32'h10, 4'h0, 32'h0,         32'hFFFF80FF};
    vecs[4]  = '{1'b0, 3'b101, 32'h12, 32'h0,         32'h80FF1234, 1,   1'b0, 4,  32'h10, 4'h0, 32'h0,         32'h000080FF};
    vecs[5]  = '{1'b1, 3'b000, 32'h21, 32'h000000AB,  32'h0,        0,   1'b0, 3,  32'h20, 4'h2, 32'hABABABAB,  32'h000080FF};
    vecs[6]  = '{1'b1, 3'b001, 32'h22, 32'h55551234,  32'h0,        0,   1'b0, 3,  32'h20, 4'hC, 32'h12341234,  32'h000080FF};
    vecs[7]  = '{1'b1, 3'b010, 32'h30, 32'hCAFEF00D,  32'h0,        2,   1'b0, 5,  32'h30, 4'hF, 32'hCAFEF00D,  32'h000080FF};
    vecs[8]  = '{1'b0, 3'b010, 32'h06, 32'h0,         32'h11111111, 0,   1'b1, 2,  32'h04, 4'h0, 32'h0,         32'h000080FF};
    vecs[9]  = '{1'b0, 3'b001, 32'h15, 32'h0,         32'h22222222, 0,   1'b1, 2,  32'h14, 4'h0, 32'h0,         32'h000080FF};
    vecs[10] = '{1'b0, 3'b011, 32'h00, 32'h0,         32'h33333333, 0,   1'b1, 2,  32'h00, 4'h0, 32'h0,         32'h000080FF};
    vecs[11] = '{1'b1, 3'b100, 32'h00, 32'h44444444,  32'h0,        0,   1'b1, 2,  32'h00, 4'h0, 32'h0,         32'h000080FF};
    vecs[12] = '{1'b0, 3'b010, 32'h40, 32'h0,         32'h55555555, 100, 1'b1, 18, 32'h40, 4'h0, 32'h0,         32'h000080FF};
    vecs[13] = '{1'b0, 3'b010, 32'h44, 32'h0,         32'h12345678, 5,   1'b0, 8,  32'h44, 4'h0, 32'h0,         32'h12345678};
    vecs[14] = '{1'b0, 3'b000, 32'h01, 32'h0,         32'h00007F00, 0,   1'b0, 3,  32'h00, 4'h0, 32'h0,         32'h0000007F};
    vecs[15] = '{1'b0, 3'b101, 32'h10, 32'h0,         32'hABCD8001, 0,   1'b0, 3,  32'h10, 4'h0, 32'h0,         32'h00008001};

    rst_n = 1'b0; lsu_valid = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALUResult = 32'h0; WriteData = 32'h0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 32'h0;
    #3;
    check("rst.stall",    32'(stall), 32'd0);
    check("rst.done",     32'(done), 32'd0);
    check("rst.err",      32'(err), 32'd0);
    check("rst.mem_req",  32'(mem_bus.mem_req), 32'd0);
    check("rst.mem_we",   32'(mem_bus.mem_we), 32'd0);
    check("rst.mem_addr", mem_bus.mem_addr, 32'h0);
    check("rst.wdata",    mem_bus.mem_wdata, 32'h0);
    check("rst.wstrb",    32'(mem_bus.mem_wstrb), 32'd0);
    check("rst.rdata",    ReadData, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd,
              vecs[i].rd, vecs[i].waits, vecs[i].exp_err, vecs[i].exp_lat,
              vecs[i].exp_addr, vecs[i].exp_strb, vecs[i].exp_wdata, vecs[i].exp_read);
      cur_read = vecs[i].exp_read;
    end

    // Reset asserted in the middle of an outstanding request.
    mem_bus.mem_ready = 1'b0;
    lsu_valid = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; ALUResult = 32'h80; WriteData = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    check("midrst.pre_req", 32'(mem_bus.mem_req), 32'd1);
    rst_n = 1'b0;
    lsu_valid = 1'b0;
    #1;
    check("midrst.mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("midrst.stall",   32'(stall), 32'd0);
    check("midrst.done",    32'(done), 32'd0);
    check("midrst.rdata",   ReadData, 32'h0);
    check("midrst.wstrb",   32'(mem_bus.mem_wstrb), 32'd0);
    cur_read = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn("postrst", 1'b0, 3'b010, 32'h84, 32'h0, 32'h0BADF00D, 1,
            1'b0, 4, 32'h84, 4'h0, 32'h0, 32'h0BADF00D);
    cur_read = 32'h0BADF00D;

    for (int n = 0; n < 150; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_f3    = 3'($urandom_range(0, 7));
      r_addr  = $urandom;
      r_wd    = $urandom;
      r_rd    = $urandom;
      r_sel   = int'($urandom_range(0, 9));
      r_waits = (r_sel == 9) ? TO + int'($urandom_range(0, 3)) : r_sel % 4;
      model(r_we, r_f3, r_addr, r_wd, r_rd, r_waits, cur_read, e, lat, ea, es, ew, er);
      run_txn($sformatf("r%0d", n), r_we, r_f3, r_addr, r_wd, r_rd, r_waits,
              e, lat, ea, es, ew, er);
      cur_read = er;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of top_execute.
- Consumes ALUResult (effective address) and WriteData (rs2), and runs one load or store per instruction over a req/ready handshake to data memory.
- Stalls the core while the access is outstanding.
- Returns a sign- or zero-extended ReadData to the Result mux.
- Flags misaligned, illegal-size and timed-out accesses.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width.
- ADDR_WIDTH, 32, byte-address width.
- TIMEOUT, 16, max cycles in REQ waiting for mem_ready before the access errors; must be ≥2.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- lsu_valid  input  1  execute stage presents a load/store this cycle.
- MemWrite  input  1  1=store, 0=load.
- funct3  input  3  size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- ALUResult  input  ADDR_WIDTH  byte address.
- WriteData  input  DATA_WIDTH  store data (rs2).
- stall  output  1  freeze PC/pipeline.
- ReadData  output  DATA_WIDTH  extended load result.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle error pulse; coincides with done.
- mem_req  output  1  memory request.
- mem_we  output  1  write enable.
- mem_addr  output  ADDR_WIDTH  word address; bits [1:0] forced to 0.
- mem_wdata  output  DATA_WIDTH  lane-shifted store data.
- mem_wstrb  output  4  byte strobes.
- mem_ready  input  1  memory accepts/completes the request this cycle.
- mem_rdata  input  DATA_WIDTH  read word; valid when mem_ready=1 and mem_we=0.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE.
  - stall, done, err, mem_req and mem_we are all 0.
  - mem_addr, mem_wdata and ReadData are 0; mem_wstrb=0000.
  - Reset mid-access drops mem_req immediately.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - stall = lsu_valid (combinational).
  - On lsu_valid, latch we, funct3, address and data.
  - Legal and aligned → REQ.
  - Illegal or misaligned → DONE with err flagged; no memory request is issued.
- Legality:
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠00.
- REQ:
  - mem_req=1, stall=1.
  - mem_we, mem_addr, mem_wdata and mem_wstrb are registered and held stable until mem_ready.
  - The wait counter increments each REQ cycle.
  - On mem_ready → DONE. A load captures the extended mem_rdata into ReadData in that same edge.
  - Counter reaching TIMEOUT without mem_ready → drop mem_req, DONE with err=1; ReadData unchanged.
- DONE:
  - done=1, err per access, stall=0, mem_req=0.
  - Always → IDLE.
  - lsu_valid in DONE is ignored, because it is the same instruction retiring.
- Strobes and store data:
  - Byte: wstrb = 0001 << addr[1:0]; wdata = {4{WriteData[7:0]}}.
  - Half: wstrb = 0011 << addr[1:0]; wdata = {2{WriteData[15:0]}}.
  - Word: wstrb = 1111; wdata = WriteData.
- Load extraction:
  - Byte lane selected by addr[1:0]; half lane by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- ReadData holds its last load value until the next successful load completes. Stores and errors leave it unchanged.
- Latency: minimum 3 cycles from the accept edge to done (IDLE accept, REQ with mem_ready, DONE). Each wait cycle adds one.
- mem_ready while not in REQ is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - the lsu_state_t enum {IDLE, REQ, DONE};
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
- Sub-module load_extend: combinational (mem_rdata, addr[1:0], funct3) → extended word, reusable and testable on its own.
- Strobe/lane generation stays inline.

Test Plan:
- LW at 0x0000_0010, memory returns 0xDEADBEEF with mem_ready on the first REQ cycle → mem_addr=0x10, done at cycle 3, ReadData=0xDEADBEEF, stall high for 2 cycles.
- LB addr 0x13 and LBU addr 0x13, mem_rdata=0x80FF_1234 → LB gives 0xFFFF_FF80, LBU gives 0x0000_0080. LH addr 0x12 on the same word → 0xFFFF_80FF.
- SB addr 0x21, WriteData=0x0000_00AB → mem_we=1, mem_addr=0x20, wstrb=0010, wdata=0xABABABAB. SH addr 0x22 → wstrb=1100.
- LW addr 0x06 (misaligned) → no mem_req ever asserted, done=err=1 on cycle 2, ReadData unchanged.
- mem_ready held low → err after TIMEOUT=16 REQ cycles, mem_req drops. A separate run with mem_ready after 5 wait cycles → done, err=0, request signals stable throughout.
- rst_n pulsed low mid-REQ → mem_req=0 and stall=0 immediately. After release a new LW completes normally.
